// File: rtl/registersstage1.sv
// Decode/operand stage: register read, bus-cycle setup and ALU operand latch,
// with stage-2 write-back hazard stall and jump flush. Optional: REGISTERSSTAGE1_FORWARDING_EN.
module registersstage1 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inbound_instruction,
  input  logic [31:0] inbound_address,
  output logic        fetch_stall,
  output logic [3:0]  read_index_a,
  output logic [3:0]  read_index_b,
  input  logic [31:0] read_data_a,
  input  logic [31:0] read_data_b,
  input  logic        stage2_write,
  input  logic        stage2_write_immediate,
  input  logic [3:0]  stage2_write_index,
  input  logic [31:0] stage2_write_data,
  input  logic        jump,
  output logic [31:0] outbound_instruction,
  output logic [31:0] outbound_address,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_out,
  output logic        bus_read,
  output logic        bus_write,
  output logic [1:0]  bus_cycle_width
);

  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_ALU    = 5'd1,
    OP_ALUMI  = 5'd2,
    OP_ALUM   = 5'd3,
    OP_LOAD   = 5'd4,
    OP_STORE  = 5'd5,
    OP_LOADI  = 5'd6,
    OP_BRANCH = 5'd7,
    OP_JUMP   = 5'd8
  } opcode_t;

  typedef enum logic [1:0] {
    CW_BYTE = 2'd0,
    CW_WORD = 2'd1,
    CW_LONG = 2'd2,
    CW_RSVD = 2'd3
  } t_cycle_width;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0
  } alu_op_t;

  opcode_t      op;
  logic [3:0]   field_d;
  logic [3:0]   field_a;
  logic [3:0]   field_b;
  logic [31:0]  sext12;
  logic [31:0]  sext8;
  t_cycle_width field_w;

  assign op      = opcode_t'(inbound_instruction[31:27]);
  assign field_w = t_cycle_width'(inbound_instruction[26:25]);
  assign field_d = inbound_instruction[23:20];
  assign field_a = inbound_instruction[19:16];
  assign field_b = inbound_instruction[15:12];
  assign sext12  = {{20{inbound_instruction[11]}}, inbound_instruction[11:0]};
  assign sext8   = {{24{inbound_instruction[7]}}, inbound_instruction[7:0]};

  logic unused_bit24;
  assign unused_bit24 = inbound_instruction[24];

  // STORE fetches its data register through port B
  assign read_index_a = field_a;
  assign read_index_b = (op == OP_STORE) ? field_d : field_b;

  logic uses_a;
  logic uses_b;

  always_comb begin
    uses_a = 1'b0;
    uses_b = 1'b0;
    case (op)
      OP_ALU, OP_ALUM: begin
        uses_a = 1'b1;
        uses_b = 1'b1;
      end
      OP_STORE: begin
        uses_a = 1'b1;
        uses_b = 1'b1;
      end
      OP_ALUMI, OP_LOAD, OP_JUMP: uses_a = 1'b1;
      default: ;
    endcase
  end

  logic match_a;
  logic match_b;
  logic hazard;
  logic bubble;
  logic [31:0] operand_a;
  logic [31:0] operand_b;

  assign match_a = uses_a && (stage2_write_index == read_index_a);
  assign match_b = uses_b && (stage2_write_index == read_index_b);

`ifdef REGISTERSSTAGE1_FORWARDING_EN
  // Register-write results are forwarded; only immediate writes still stall
  assign hazard    = stage2_write_immediate && (match_a || match_b);
  assign operand_a = (stage2_write && match_a) ? stage2_write_data : read_data_a;
  assign operand_b = (stage2_write && match_b) ? stage2_write_data : read_data_b;
`else
  assign hazard    = (stage2_write || stage2_write_immediate) && (match_a || match_b);
  assign operand_a = read_data_a;
  assign operand_b = read_data_b;
`endif

  assign bubble      = hazard || jump;
  assign fetch_stall = reset && hazard && !jump;

  logic [31:0]  nxt_instruction;
  logic [31:0]  nxt_address;
  logic [3:0]   nxt_alu_op;
  logic [31:0]  nxt_alu_a;
  logic [31:0]  nxt_alu_b;
  logic [31:0]  nxt_bus_address;
  logic [31:0]  nxt_bus_data;
  logic         nxt_bus_read;
  logic         nxt_bus_write;
  t_cycle_width nxt_width;

  always_comb begin
    nxt_instruction = inbound_instruction;
    nxt_address     = inbound_address;
    nxt_alu_op      = '0;
    nxt_alu_a       = '0;
    nxt_alu_b       = '0;
    nxt_bus_address = '0;
    nxt_bus_data    = '0;
    nxt_bus_read    = 1'b0;
    nxt_bus_write   = 1'b0;
    nxt_width       = CW_BYTE;
    if (bubble) begin
      nxt_instruction = {OP_NOP, 27'h0};
      nxt_address     = '0;
    end else begin
      case (op)
        OP_LOAD: begin
          nxt_bus_address = operand_a + sext12;
          nxt_bus_read    = 1'b1;
          nxt_width       = field_w;
        end
        OP_STORE: begin
          nxt_bus_address = operand_a + sext12;
          nxt_bus_data    = operand_b;
          nxt_bus_write   = 1'b1;
          nxt_width       = field_w;
        end
        OP_ALU: begin
          nxt_alu_op = inbound_instruction[11:8];
          nxt_alu_a  = operand_a;
          nxt_alu_b  = operand_b;
        end
        OP_ALUMI: begin
          nxt_alu_op = inbound_instruction[11:8];
          nxt_alu_a  = operand_a;
          nxt_alu_b  = sext8;
        end
        OP_ALUM: begin
          nxt_alu_op      = inbound_instruction[11:8];
          nxt_alu_a       = operand_a;
          nxt_bus_address = operand_b;
          nxt_bus_read    = 1'b1;
          nxt_width       = CW_LONG;
        end
        OP_BRANCH: begin
          nxt_alu_op = ALU_ADD;
          nxt_alu_a  = inbound_address;
          nxt_alu_b  = {sext12[29:0], 2'b00};
        end
        OP_JUMP: begin
          nxt_alu_op = ALU_ADD;
          nxt_alu_a  = operand_a;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outbound_instruction <= {OP_NOP, 27'h0};
      outbound_address     <= '0;
      alu_op               <= '0;
      alu_a                <= '0;
      alu_b                <= '0;
      bus_address          <= '0;
      bus_data_out         <= '0;
      bus_read             <= 1'b0;
      bus_write            <= 1'b0;
      bus_cycle_width      <= '0;
    end else begin
      outbound_instruction <= nxt_instruction;
      outbound_address     <= nxt_address;
      alu_op               <= nxt_alu_op;
      alu_a                <= nxt_alu_a;
      alu_b                <= nxt_alu_b;
      bus_address          <= nxt_bus_address;
      bus_data_out         <= nxt_bus_data;
      bus_read             <= nxt_bus_read;
      bus_write            <= nxt_bus_write;
      bus_cycle_width      <= nxt_width;
    end
  end

endmodule

// File: tb/tb_registersstage1.sv
// Scoreboard bench for registersstage1: directed vectors push expected stage outputs,
// a monitor pops and compares after each rising edge.
module tb_registersstage1;

  localparam logic [4:0] NOP = 5'd0, ALU = 5'd1, ALUMI = 5'd2, ALUM = 5'd3, LOAD = 5'd4,
                         STORE = 5'd5, LOADI = 5'd6, BRANCH = 5'd7, JUMP = 5'd8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inbound_instruction, inbound_address;
  logic        fetch_stall;
  logic [3:0]  read_index_a, read_index_b;
  logic [31:0] read_data_a, read_data_b;
  logic        stage2_write, stage2_write_immediate;
  logic [3:0]  stage2_write_index;
  logic [31:0] stage2_write_data;
  logic        jump;
  logic [31:0] outbound_instruction, outbound_address;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, bus_address, bus_data_out;
  logic        bus_read, bus_write;
  logic [1:0]  bus_cycle_width;

  logic [31:0] regs [16];
  assign read_data_a = regs[read_index_a];
  assign read_data_b = regs[read_index_b];

  registersstage1 dut (
    .clock(clock), .reset(reset),
    .inbound_instruction(inbound_instruction), .inbound_address(inbound_address),
    .fetch_stall(fetch_stall),
    .read_index_a(read_index_a), .read_index_b(read_index_b),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .stage2_write(stage2_write), .stage2_write_immediate(stage2_write_immediate),
    .stage2_write_index(stage2_write_index), .stage2_write_data(stage2_write_data),
    .jump(jump),
    .outbound_instruction(outbound_instruction), .outbound_address(outbound_address),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_read(bus_read), .bus_write(bus_write), .bus_cycle_width(bus_cycle_width)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] instr, addr, aa, ab, baddr, bdout;
    logic [3:0]  aop;
    logic        rd, wr;
    logic [1:0]  w;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [1:0] w,
                                      input logic [3:0] d, input logic [3:0] a,
                                      input logic [3:0] b, input logic [11:0] imm);
    return {op, w, 1'b0, d, a, b, imm};
  endfunction

  function automatic exp_t mk(input string nm, input logic [31:0] instr, input logic [31:0] addr,
                              input logic [3:0] aop, input logic [31:0] aa, input logic [31:0] ab,
                              input logic [31:0] baddr, input logic [31:0] bdout,
                              input logic rd, input logic wr, input logic [1:0] w);
    exp_t e;
    e.name = nm; e.instr = instr; e.addr = addr; e.aop = aop; e.aa = aa; e.ab = ab;
    e.baddr = baddr; e.bdout = bdout; e.rd = rd; e.wr = wr; e.w = w;
    return e;
  endfunction

  function automatic exp_t bubble(input string nm);
    return mk(nm, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
  endfunction

  // Monitor: the stage presents a new result after every rising edge
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, ".instr"}, outbound_instruction, e.instr);
      chk({e.name, ".addr"},  outbound_address, e.addr);
      chk({e.name, ".alu_op"}, {28'h0, alu_op}, {28'h0, e.aop});
      chk({e.name, ".alu_a"}, alu_a, e.aa);
      chk({e.name, ".alu_b"}, alu_b, e.ab);
      chk({e.name, ".bus_address"}, bus_address, e.baddr);
      chk({e.name, ".bus_data_out"}, bus_data_out, e.bdout);
      chk({e.name, ".bus_read"}, {31'h0, bus_read}, {31'h0, e.rd});
      chk({e.name, ".bus_write"}, {31'h0, bus_write}, {31'h0, e.wr});
      chk({e.name, ".width"}, {30'h0, bus_cycle_width}, {30'h0, e.w});
    end
  end

  task automatic vec(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                     input logic s2w, input logic s2wi, input logic [3:0] s2i,
                     input logic [31:0] s2d, input logic jmp, input logic exp_stall);
    reset                  = 1'b1;
    inbound_instruction    = instr;
    inbound_address        = pc;
    stage2_write           = s2w;
    stage2_write_immediate = s2wi;
    stage2_write_index     = s2i;
    stage2_write_data      = s2d;
    jump                   = jmp;
    #1;
    chk({nm, ".fetch_stall"}, {31'h0, fetch_stall}, {31'h0, exp_stall});
  endtask

  logic [31:0] i_alu, i_ld;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    regs[5] = 32'hDEADBEEF;
    i_alu = enc(ALU, 2'd0, 4'd3, 4'd1, 4'd2, 12'h000);

    // reset held with a live hazard on the inputs
    reset = 1'b0;
    inbound_instruction = i_alu; inbound_address = 32'h10;
    stage2_write = 1'b1; stage2_write_immediate = 1'b0;
    stage2_write_index = 4'd1; stage2_write_data = 32'h0; jump = 1'b0;
    #1;
    chk("reset.fetch_stall", {31'h0, fetch_stall}, 32'h0);
    chk("reset.instr", outbound_instruction, 32'h0);
    chk("reset.bus_read", {31'h0, bus_read}, 32'h0);
    q.push_back(bubble("reset"));

    @(negedge clock);
    vec("alu", i_alu, 32'h10, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("alu.read_index_a", {28'h0, read_index_a}, 32'd1);
    chk("alu.read_index_b", {28'h0, read_index_b}, 32'd2);
    q.push_back(mk("alu", i_alu, 32'h10, 4'h0, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
    regs[2] = 32'h100;
    i_ld = enc(LOAD, 2'd0, 4'd4, 4'd2, 4'd0, 12'hFFC);
    vec("load", i_ld, 32'h14, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("load", i_ld, 32'h14, 4'h0, 32'h0, 32'h0, 32'hFC, 32'h0, 1'b1, 1'b0, 2'd0));

    @(negedge clock);
    vec("nop", 32'h0, 32'h18, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("nop", 32'h0, 32'h18, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
    vec("store", enc(STORE, 2'd1, 4'd5, 4'd1, 4'd9, 12'h008), 32'h1C, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("store.read_index_b", {28'h0, read_index_b}, 32'd5);
    q.push_back(mk("store", enc(STORE, 2'd1, 4'd5, 4'd1, 4'd9, 12'h008), 32'h1C, 4'h0, 32'h0, 32'h0,
                   32'h0D, 32'hDEADBEEF, 1'b0, 1'b1, 2'd1));

    @(negedge clock);
    vec("alumi", enc(ALUMI, 2'd0, 4'd6, 4'd1, 4'd0, 12'h3F0), 32'h20, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("alumi", enc(ALUMI, 2'd0, 4'd6, 4'd1, 4'd0, 12'h3F0), 32'h20, 4'h3, 32'd5,
                   32'hFFFFFFF0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
    vec("alum", enc(ALUM, 2'd0, 4'd6, 4'd1, 4'd2, 12'h200), 32'h24, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("alum", enc(ALUM, 2'd0, 4'd6, 4'd1, 4'd2, 12'h200), 32'h24, 4'h2, 32'd5, 32'h0,
                   32'h100, 32'h0, 1'b1, 1'b0, 2'd2));

    @(negedge clock);
    vec("branch", enc(BRANCH, 2'd0, 4'd0, 4'd0, 4'd0, 12'h003), 32'h40, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("branch", enc(BRANCH, 2'd0, 4'd0, 4'd0, 4'd0, 12'h003), 32'h40, 4'h0, 32'h40, 32'hC,
                   32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
    vec("branch_jump", enc(BRANCH, 2'd0, 4'd0, 4'd0, 4'd0, 12'h003), 32'h40, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
    q.push_back(bubble("branch_jump"));

    @(negedge clock);
    vec("branch_neg", enc(BRANCH, 2'd0, 4'd0, 4'd0, 4'd0, 12'hFFF), 32'h80, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("branch_neg", enc(BRANCH, 2'd0, 4'd0, 4'd0, 4'd0, 12'hFFF), 32'h80, 4'h0, 32'h80,
                   32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
    vec("jump_op", enc(JUMP, 2'd0, 4'd0, 4'd1, 4'd0, 12'h000), 32'h44, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("jump_op", enc(JUMP, 2'd0, 4'd0, 4'd1, 4'd0, 12'h000), 32'h44, 4'h0, 32'd5, 32'h0,
                   32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
    vec("loadi", enc(LOADI, 2'd0, 4'd7, 4'd0, 4'd0, 12'h123), 32'h48, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("loadi", enc(LOADI, 2'd0, 4'd7, 4'd0, 4'd0, 12'h123), 32'h48, 4'h0, 32'h0, 32'h0,
                   32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    // Stage 2 writes r2=0x20 while the LOAD reads r2
    i_ld = enc(LOAD, 2'd1, 4'd4, 4'd2, 4'd0, 12'hFFC);
    @(negedge clock);
`ifdef REGISTERSSTAGE1_FORWARDING_EN
    vec("ld_haz", i_ld, 32'h4C, 1'b1, 1'b0, 4'd2, 32'h20, 1'b0, 1'b0);
    q.push_back(mk("ld_haz", i_ld, 32'h4C, 4'h0, 32'h0, 32'h0, 32'h1C, 32'h0, 1'b1, 1'b0, 2'd1));
`else
    vec("ld_haz", i_ld, 32'h4C, 1'b1, 1'b0, 4'd2, 32'h20, 1'b0, 1'b1);
    q.push_back(bubble("ld_haz"));
`endif
    @(negedge clock);
    regs[2] = 32'h20;
    vec("ld_retry", i_ld, 32'h4C, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("ld_retry", i_ld, 32'h4C, 4'h0, 32'h0, 32'h0, 32'h1C, 32'h0, 1'b1, 1'b0, 2'd1));

    @(negedge clock);
    vec("imm_haz", i_alu, 32'h50, 1'b0, 1'b1, 4'd1, 32'h99, 1'b0, 1'b1);
    q.push_back(bubble("imm_haz"));
    @(negedge clock);
    regs[1] = 32'h99;
    vec("imm_retry", i_alu, 32'h50, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("imm_retry", i_alu, 32'h50, 4'h0, 32'h99, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
`ifdef REGISTERSSTAGE1_FORWARDING_EN
    vec("r0_haz", enc(ALU, 2'd0, 4'd3, 4'd0, 4'd2, 12'h000), 32'h54, 1'b1, 1'b0, 4'd0, 32'h11, 1'b0, 1'b0);
    q.push_back(mk("r0_haz", enc(ALU, 2'd0, 4'd3, 4'd0, 4'd2, 12'h000), 32'h54, 4'h0, 32'h11, 32'h20,
                   32'h0, 32'h0, 1'b0, 1'b0, 2'd0));
`else
    vec("r0_haz", enc(ALU, 2'd0, 4'd3, 4'd0, 4'd2, 12'h000), 32'h54, 1'b1, 1'b0, 4'd0, 32'h11, 1'b0, 1'b1);
    q.push_back(bubble("r0_haz"));
`endif

    // Write to the LOAD's destination register is not a read dependency
    @(negedge clock);
    vec("dest_nohaz", enc(LOAD, 2'd0, 4'd4, 4'd2, 4'd0, 12'h004), 32'h58, 1'b1, 1'b0, 4'd4, 32'h55, 1'b0, 1'b0);
    q.push_back(mk("dest_nohaz", enc(LOAD, 2'd0, 4'd4, 4'd2, 4'd0, 12'h004), 32'h58, 4'h0, 32'h0, 32'h0,
                   32'h24, 32'h0, 1'b1, 1'b0, 2'd0));

    @(negedge clock);
    vec("br_nohaz", enc(BRANCH, 2'd0, 4'd0, 4'd0, 4'd0, 12'h001), 32'h60, 1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("br_nohaz", enc(BRANCH, 2'd0, 4'd0, 4'd0, 4'd0, 12'h001), 32'h60, 4'h0, 32'h60, 32'h4,
                   32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    @(negedge clock);
    vec("jump_haz", i_alu, 32'h64, 1'b0, 1'b1, 4'd1, 32'h0, 1'b1, 1'b0);
    q.push_back(bubble("jump_haz"));

    @(negedge clock);
    vec("pre_rst_ld", enc(LOAD, 2'd0, 4'd4, 4'd2, 4'd0, 12'h000), 32'h68, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("pre_rst_ld", enc(LOAD, 2'd0, 4'd4, 4'd2, 4'd0, 12'h000), 32'h68, 4'h0, 32'h0, 32'h0,
                   32'h20, 32'h0, 1'b1, 1'b0, 2'd0));

    // Reset asserted while a stall is active
    @(negedge clock);
    vec("rst_stall", i_alu, 32'h6C, 1'b0, 1'b1, 4'd2, 32'h0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_stall.async_stall", {31'h0, fetch_stall}, 32'h0);
    chk("rst_stall.async_instr", outbound_instruction, 32'h0);
    chk("rst_stall.async_bus_read", {31'h0, bus_read}, 32'h0);
    chk("rst_stall.async_bus_address", bus_address, 32'h0);
    q.push_back(bubble("rst_stall"));

    @(negedge clock);
    vec("post_rst", i_alu, 32'h70, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    q.push_back(mk("post_rst", i_alu, 32'h70, 4'h0, 32'h99, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    #3;
    chk("scoreboard_drain", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/registersstage1.md
# registersstage1

Decode/operand stage sitting between instruction fetch and `registersstage2`. Reads the register file for the instruction in hand, drives the data-bus cycle for LOAD/STORE/ALUM, and latches ALU operands so the ALU result is valid during the stage-2 cycle. It detects the one-cycle write-back hazard against stage 2 and flushes wrong-path instructions when stage 2 signals `jump`.

## Interface
- No parameters.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inbound_instruction`  in  32  instruction from fetch.
- `inbound_address`  in  32  PC of that instruction.
- `fetch_stall`  out  1  combinational; fetch holds PC/instruction while high.
- `read_index_a`, `read_index_b`  out  4 each  combinational: `inbound_instruction[19:16]`, `[15:12]`.
- `read_data_a`, `read_data_b`  in  32 each  register file read ports (combinational).
- `stage2_write`, `stage2_write_immediate`  in  1 each  stage-2 `write` / `write_immediate`.
- `stage2_write_index`  in  4  stage-2 `write_index`.
- `stage2_write_data`  in  32  stage-2 `write_data`.
- `jump`  in  1  stage-2 branch-taken.
- `outbound_instruction`, `outbound_address`  out  32 each  to stage 2.
- `alu_op`  out  4;  `alu_a`, `alu_b`  out  32 each  registered ALU operands.
- `bus_address`  out  32;  `bus_data_out`  out  32;  `bus_read`, `bus_write`  out  1 each;  `bus_cycle_width`  out  2  registered bus cycle (`t_cycle_width`).

## Operation
- Fields: opcode `[31:27]`, width `[26:25]`, dest/store-data reg `[23:20]`, reg A `[19:16]`, reg B `[15:12]`, ALU op `[11:8]`, imm12 `[11:0]`, imm8 `[7:0]`.
- LOAD: `bus_address` = A + sext(imm12), `bus_read`=1, width from `[26:25]`.
- STORE: same address; `bus_data_out` = reg `[23:20]` (read via port B, `read_index_b` switches to `[23:20]` for STORE), `bus_write`=1.
- ALU: `alu_a`=A, `alu_b`=B, `alu_op`=`[11:8]`.
- ALUMI: `alu_b` = sext(imm8). ALUM: `bus_address`=B, `bus_read`=1, width long; `alu_a`=A.
- BRANCH: `alu_a`=PC, `alu_b`=sext(imm12)<<2, `alu_op`=ADD. JUMP: `alu_a`=A, `alu_b`=0, ADD.
- LOADI, NOP, others: operands 0, no bus cycle; instruction passed through.
- Hazard: `stage2_write` or `stage2_write_immediate` high and `stage2_write_index` equals any register the current opcode reads (index 0 included) -> `fetch_stall`=1, outbound = NOP, no bus cycle; instruction re-decoded next cycle.
- Flush: `jump`=1 -> outbound = NOP, no bus cycle, `fetch_stall`=0. Jump outranks hazard.
- Bus strobes are single-cycle, deasserted on every bubble.

## Timing
- Active reset: `outbound_instruction`={NOP,27'h0}; all other registered outputs 0; `fetch_stall`=0 while held. Asynchronous assert, synchronous deassert release at next edge.
- Latency: one clock, inbound -> outbound and ALU operands/bus signals.
- Stall costs exactly one bubble per hazard; back-to-back dependents stall once each.
- Reset mid-stall: stall drops immediately; first post-reset edge latches fresh instruction.

## Configuration
- `REGISTERSSTAGE1_FORWARDING_EN`: defined -> hazard on `stage2_write` (not immediate) is resolved by substituting `stage2_write_data` for the matching operand, no stall; immediate-write hazards still stall. Undefined -> all hazards stall as above.

## Test plan
- ALU r3=r1+r2, r1=5, r2=7 -> next cycle `alu_a`=5, `alu_b`=7, `alu_op`=ADD, outbound = ALU instr.
- LOAD r4,(r2+-4), r2=0x100, byte -> `bus_address`=0xFC, `bus_read`=1 one cycle, width byte.
- Stage2 write r2=0x20 while LOAD uses r2 -> `fetch_stall`=1, NOP out; next cycle address 0x1C (with `_EN`: no stall, address 0x1C directly).
- BRANCH at PC 0x40, imm12=3 with `jump`=1 same cycle -> NOP out, no bus strobe; without jump -> `alu_a`=0x40, `alu_b`=0xC.
- Reset asserted mid-stall -> NOP outbound, strobes 0, `fetch_stall`=0 immediately.
